// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: MemtoReg codes,
// FSM state encoding and default datapath widths.
package mem_stage_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_W  = 5;

   localparam logic [1:0] MTR_ALU = 2'd0;
   localparam logic [1:0] MTR_MEM = 2'd1;
   localparam logic [1:0] MTR_PC  = 2'd2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register: loads on enable, holds otherwise.
// Read data only updates when a load actually completes.
module mem_wb_reg
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_W  = DEF_REG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              rd_en,
   input  logic              reg_write,
   input  logic [1:0]        mem_to_reg,
   input  logic [DATA_W-1:0] read_data,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [REG_W-1:0]  write_reg,
   input  logic [31:0]       pc,
   output logic              reg_write_r,
   output logic [1:0]        mem_to_reg_r,
   output logic [DATA_W-1:0] read_data_r,
   output logic [DATA_W-1:0] alu_result_r,
   output logic [REG_W-1:0]  write_reg_r,
   output logic [31:0]       pc_r
);

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write_r  <= 1'b0;
         mem_to_reg_r <= '0;
         read_data_r  <= '0;
         alu_result_r <= '0;
         write_reg_r  <= '0;
         pc_r         <= '0;
      end else if (en) begin
         reg_write_r  <= reg_write;
         mem_to_reg_r <= mem_to_reg;
         alu_result_r <= alu_result;
         write_reg_r  <= write_reg;
         pc_r         <= pc;
         if (rd_en) read_data_r <= read_data;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: D-cache request/miss handling, pipeline stall,
// endian swap, stall-cycle counter and the MEM/WB register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = 30,
   parameter int REG_W       = DEF_REG_W,
   parameter bit SWAP_ENDIAN = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              RegWrite_i,
   input  logic [1:0]        MemtoReg_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic [DATA_W-1:0] ALUResult_i,
   input  logic [DATA_W-1:0] MemWriteData_i,
   input  logic [REG_W-1:0]  WriteRegDest_i,
   input  logic [31:0]       PC_i,
   input  logic              stall_i,
   output logic              DCACHE_ren_o,
   output logic              DCACHE_wen_o,
   output logic [ADDR_W-1:0] DCACHE_addr_o,
   output logic [DATA_W-1:0] DCACHE_wdata_o,
   input  logic [DATA_W-1:0] DCACHE_rdata_i,
   input  logic              DCACHE_stall_i,
   output logic              mem_stall_o,
   output logic              RegWrite_o,
   output logic [1:0]        MemtoReg_o,
   output logic [DATA_W-1:0] ReadData_o,
   output logic [DATA_W-1:0] ALUResult_o,
   output logic [REG_W-1:0]  WriteRegDest_o,
   output logic [31:0]       PC_o,
   output logic [31:0]       stall_cycles_o
);

   state_t            state;
   state_t            state_nxt;
   logic              access;
   logic              rd_req;
   logic              wr_req;
   logic              rd_done;
   logic              wb_en;
   logic [DATA_W-1:0] wdata_sw;
   logic [DATA_W-1:0] rdata_sw;

   // A read+write combination is treated as a store.
   assign wr_req  = MemWrite_i & ~rst_i;
   assign rd_req  = MemRead_i & ~MemWrite_i & ~rst_i;
   assign access  = (MemRead_i | MemWrite_i) & ~rst_i;
   assign rd_done = rd_req & ~DCACHE_stall_i;
   assign wb_en   = ~mem_stall_o & ~stall_i;

   assign mem_stall_o    = access & DCACHE_stall_i;
   assign DCACHE_ren_o   = rd_req;
   assign DCACHE_wen_o   = wr_req;
   assign DCACHE_addr_o  = ALUResult_i[ADDR_W+1:2];
   assign DCACHE_wdata_o = wdata_sw;

   always_comb begin
      wdata_sw = MemWriteData_i;
      rdata_sw = DCACHE_rdata_i;
      if (SWAP_ENDIAN) begin
         for (int b = 0; b < DATA_W / 8; b++) begin
            wdata_sw[8*b +: 8] = MemWriteData_i[DATA_W-8-8*b +: 8];
            rdata_sw[8*b +: 8] = DCACHE_rdata_i[DATA_W-8-8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (mem_stall_o)  state_nxt = ST_WAIT;
         ST_WAIT: if (!mem_stall_o) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)            stall_cycles_o <= '0;
      else if (mem_stall_o) stall_cycles_o <= stall_cycles_o + 32'd1;
   end

   mem_wb_reg #(
      .DATA_W (DATA_W),
      .REG_W  (REG_W)
   ) u_mem_wb (
      .clk          (clk_i),
      .rst          (rst_i),
      .en           (wb_en),
      .rd_en        (rd_done),
      .reg_write    (RegWrite_i),
      .mem_to_reg   (MemtoReg_i),
      .read_data    (rdata_sw),
      .alu_result   (ALUResult_i),
      .write_reg    (WriteRegDest_i),
      .pc           (PC_i),
      .reg_write_r  (RegWrite_o),
      .mem_to_reg_r (MemtoReg_o),
      .read_data_r  (ReadData_o),
      .alu_result_r (ALUResult_o),
      .write_reg_r  (WriteRegDest_o),
      .pc_r         (PC_o)
   );

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage pipeline; sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Issues load/store requests to the data cache and holds them across cache misses.
- Raises a pipeline-wide stall during misses.
- Contains the MEM/WB pipeline register that feeds write-back and WB forwarding.

Parameters:
DATA_W, 32, data and ALU result width
ADDR_W, 30, word address width to D-cache (byte address bits [31:2])
REG_W, 5, register index width
SWAP_ENDIAN, 1, 1 = byte-swap write data and read data (little-endian core, big-endian cache); 0 = pass through

Ports:
clk_i  in  1  clock, all flops on rising edge
rst_i  in  1  reset, synchronous, active-high
RegWrite_i  in  1  from EX/MEM
MemtoReg_i  in  2  from EX/MEM (0 ALU, 1 mem, 2 PC link)
MemRead_i  in  1  from EX/MEM, load
MemWrite_i  in  1  from EX/MEM, store
ALUResult_i  in  DATA_W  from EX/MEM, byte address / ALU value
MemWriteData_i  in  DATA_W  from EX/MEM, store data
WriteRegDest_i  in  REG_W  from EX/MEM
PC_i  in  32  from EX/MEM, link value
stall_i  in  1  external freeze (I-cache stall / hazard unit)
DCACHE_ren_o  out  1  read request
DCACHE_wen_o  out  1  write request
DCACHE_addr_o  out  ADDR_W  word address = ALUResult_i[31:2]
DCACHE_wdata_o  out  DATA_W  store data, swapped when SWAP_ENDIAN
DCACHE_rdata_i  in  DATA_W  load data, valid when request is high and DCACHE_stall_i is 0
DCACHE_stall_i  in  1  cache busy / miss (combinational from request)
mem_stall_o  out  1  freeze IF/ID/EX and EX/MEM (drives EX_MEM_write low)
RegWrite_o  out  1  MEM/WB
MemtoReg_o  out  2  MEM/WB
ReadData_o  out  DATA_W  MEM/WB, load data after swap
ALUResult_o  out  DATA_W  MEM/WB
WriteRegDest_o  out  REG_W  MEM/WB
PC_o  out  32  MEM/WB
stall_cycles_o  out  32  count of cycles with mem_stall_o=1, wraps modulo 2^32

Behaviour:
- FSM states: IDLE, WAIT.
- access = MemRead_i | MemWrite_i.
- Both read and write set is illegal; it is treated as a write (DCACHE_ren_o=0).
- Requests are combinational from the EX/MEM inputs:
  - DCACHE_wen_o = MemWrite_i & ~rst_i
  - DCACHE_ren_o = MemRead_i & ~MemWrite_i & ~rst_i
  - asserted in both states
  - addr and wdata held stable while in WAIT, because EX/MEM is frozen by mem_stall_o.
- IDLE:
  - access & DCACHE_stall_i=1 -> go to WAIT; mem_stall_o=1 this cycle.
  - access & DCACHE_stall_i=0 (hit) -> complete in the same cycle; mem_stall_o=0.
  - no access -> stay in IDLE; mem_stall_o=0.
- WAIT:
  - DCACHE_stall_i=1 -> stay in WAIT; mem_stall_o=1.
  - DCACHE_stall_i=0 -> complete this cycle; mem_stall_o=0; next state IDLE.
- mem_stall_o is combinational: access & DCACHE_stall_i.
  - It is 0 whenever access=0, even if the cache drives stall.
- MEM/WB load enable = ~mem_stall_o & ~stall_i.
  - On enable, capture RegWrite, MemtoReg, ALUResult, WriteRegDest, PC.
  - On enable, capture ReadData = swap(DCACHE_rdata_i) when a read completes, else ReadData holds its previous value.
  - When not enabled, MEM/WB holds every field, so the WB forwarding value is preserved.
- Latency: hit = 1 cycle (request cycle to MEM/WB update); miss = N+1 cycles, where N is the number of cycles with DCACHE_stall_i=1.
- Completion with stall_i=1: MEM/WB does not load; EX/MEM is held by the hazard unit, so the request is re-issued next cycle.
  - Re-issue is permitted: loads are side-effect free and a repeated store writes the same data to the same address.
- swap(x) = {x[7:0],x[15:8],x[23:16],x[31:24]} when SWAP_ENDIAN=1, else x. It applies to both wdata and rdata.
- stall_cycles_o increments by 1 on every cycle with mem_stall_o=1 and rst_i=0.
- Reset (rst_i=1 at a clock edge):
  - state -> IDLE.
  - all MEM/WB outputs -> 0; stall_cycles_o -> 0.
  - while rst_i is high, ren/wen/mem_stall_o are forced to 0, including a reset arriving mid-WAIT. The aborted access is not retried.

Decomposition:
- Shared cpu package holds:
  - MemtoReg encodings MTR_ALU=2'd0, MTR_MEM=2'd1, MTR_PC=2'd2
  - FSM state encoding ST_IDLE, ST_WAIT
  - DATA_W and REG_W defaults
- One natural sub-module: mem_wb_reg, the enable-controlled MEM/WB register with synchronous active-high reset.
- FSM, request logic, swap and counter stay in mem_stage.

Test Plan:
- Reset: drive rst_i=1 for 2 cycles with MemRead_i=1 -> ren_o=0, mem_stall_o=0, all MEM/WB outputs 0, stall_cycles_o=0.
- Load hit: MemRead_i=1, ALUResult_i=0x0000_0104, DCACHE_stall_i=0, rdata=0x1122_3344 -> DCACHE_addr_o=0x41; next edge ReadData_o=0x4433_2211, MemtoReg_o=1, stall_cycles_o unchanged.
- Store miss: MemWrite_i=1, MemWriteData_i=0xAABB_CCDD, DCACHE_stall_i=1 for 3 cycles then 0:
  - wen_o=1 throughout; wdata_o=0xDDCC_BBAA
  - mem_stall_o=1 for exactly 3 cycles; stall_cycles_o=3
  - MEM/WB loads only on the 4th cycle
- Load miss with stall_i: load completes (DCACHE_stall_i=0) while stall_i=1 -> MEM/WB unchanged; next cycle, with stall_i=0 and a hit, MEM/WB loads the correct data.
- Reset mid-WAIT: enter WAIT, assert rst_i for 1 cycle -> ren_o=0 during reset; state IDLE; outputs 0; stall_cycles_o=0.
- Non-memory op: RegWrite_i=1, MemtoReg_i=2, PC_i=0x0000_0040, DCACHE_stall_i=1 -> ren/wen=0, mem_stall_o=0; next edge PC_o=0x40, RegWrite_o=1.
